// File: rtl/program_loader.sv
// Byte-stream program memory loader: assembles big-endian 16-bit words,
// zero-fills the rest of memory and holds the CPU in reset until done.
module program_loader #(
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int RST_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              pm_we,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [15:0]       pm_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              err_odd,
    output logic              err_ovf
);

    localparam int CNT_W = (RST_HOLD < 2) ? 1 : $clog2(RST_HOLD);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  HOLD_INIT = CNT_W'(RST_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HI, S_LO, S_WR, S_DRAIN, S_FILL, S_HOLD, S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        hi_byte, lo_byte;
    logic              last_f;
    logic [CNT_W-1:0]  hold_cnt;
    logic              hs;
    logic              at_end;

    assign hs     = in_valid && in_ready;
    assign at_end = (addr == LAST_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_HI;
            S_HI:    if (hs) state_nxt = in_last ? S_WR : S_LO;
            S_LO:    if (hs) state_nxt = S_WR;
            S_WR: begin
                if (last_f)      state_nxt = at_end ? S_HOLD : S_FILL;
                else if (at_end) state_nxt = S_DRAIN;
                else             state_nxt = S_HI;
            end
            S_DRAIN: if (hs && in_last) state_nxt = S_HOLD;
            S_FILL:  if (at_end) state_nxt = S_HOLD;
            S_HOLD:  if (hold_cnt == '0) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decode state and registers only; nothing flows from in_* here.
    always_comb begin
        in_ready = (state == S_HI) || (state == S_LO) || (state == S_DRAIN);
        pm_we    = (state == S_WR) || (state == S_FILL);
        pm_addr  = addr;
        pm_wdata = (state == S_WR) ? {hi_byte, lo_byte} : 16'h0000;
        cpu_rst  = (state != S_DONE);
        busy     = (state != S_IDLE) && (state != S_DONE);
        done     = (state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr       <= '0;
            hi_byte    <= '0;
            lo_byte    <= '0;
            last_f     <= 1'b0;
            word_count <= '0;
            err_odd    <= 1'b0;
            err_ovf    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        addr       <= '0;
                        last_f     <= 1'b0;
                        word_count <= '0;
                        err_odd    <= 1'b0;
                        err_ovf    <= 1'b0;
                    end
                end
                S_HI: begin
                    if (hs) begin
                        hi_byte <= in_data;
                        if (in_last) begin
                            lo_byte <= 8'h00;
                            last_f  <= 1'b1;
                            err_odd <= 1'b1;
                        end
                    end
                end
                S_LO: begin
                    if (hs) begin
                        lo_byte <= in_data;
                        last_f  <= in_last;
                    end
                end
                S_WR: begin
                    word_count <= word_count + 1'b1;
                    if (!at_end)      addr    <= addr + 1'b1;
                    else if (!last_f) err_ovf <= 1'b1;
                end
                S_FILL: if (!at_end) addr <= addr + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hold_cnt <= '0;
        else if (state != S_HOLD && state_nxt == S_HOLD)
            hold_cnt <= HOLD_INIT;
        else if (state == S_HOLD && hold_cnt != '0)
            hold_cnt <= hold_cnt - 1'b1;
    end

endmodule
